// File: rtl/modmul_sched_if.sv
// rtl/modmul_sched_if.sv - config, request, datapath and response signals of modmul_sched
interface modmul_sched_if;
  logic        cfg_we;
  logic [63:0] cfg_q;
  logic [30:0] cfg_mu;
  logic [7:0]  cfg_k;
  logic        cfg_err;

  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_a;
  logic [63:0] req1_b;

  logic [63:0] dp_a;
  logic [63:0] dp_b;
  logic [63:0] dp_q;
  logic [30:0] dp_mu;
  logic [7:0]  dp_k;
  logic [63:0] dp_t;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_t;

  modport master (
    output cfg_we, cfg_q, cfg_mu, cfg_k,
    input  cfg_err,
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  dp_a, dp_b, dp_q, dp_mu, dp_k,
    output dp_t,
    input  rsp_valid, rsp_id, rsp_t,
    output rsp_ready
  );

  modport slave (
    input  cfg_we, cfg_q, cfg_mu, cfg_k,
    output cfg_err,
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output dp_a, dp_b, dp_q, dp_mu, dp_k,
    input  dp_t,
    output rsp_valid, rsp_id, rsp_t,
    input  rsp_ready
  );
endinterface

// File: rtl/modmul_sched.sv
// rtl/modmul_sched.sv - round-robin issue, tag pipeline and credit-limited response FIFO
// for a fixed-latency modular-multiply datapath that has no valid signal of its own.
module modmul_sched #(
  parameter int LAT   = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  modmul_sched_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic           cfg_ok_q, cfg_ok_d;
  logic           ptr_q, ptr_d;
  logic           cfg_err_q, cfg_err_d;
  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  outst_q, outst_d;
  logic [63:0]    dp_a_q, dp_a_d;
  logic [63:0]    dp_b_q, dp_b_d;
  logic [63:0]    dp_q_q, dp_q_d;
  logic [30:0]    dp_mu_q, dp_mu_d;
  logic [7:0]     dp_k_q, dp_k_d;

  logic [63:0]    mem_t_q [DEPTH];
  logic [DEPTH-1:0] mem_id_q;

  logic grant_ok;
  logic win_id;
  logic issue;
  logic push;
  logic pop;
  logic cfg_load;
  logic fifo_nempty;

  // Credits count everything issued but not yet popped, so a FIFO write always has room.
  always_comb begin
    grant_ok = cfg_ok_q && !bus.cfg_we && (outst_q < CW'(DEPTH));
    win_id   = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      win_id = ~ptr_q;
    end
    issue = grant_ok && (bus.req0_valid || bus.req1_valid);
  end

  assign fifo_nempty = (cnt_q != '0);
  assign push        = tag_v_q[LAT-1];
  assign pop         = fifo_nempty && bus.rsp_ready;
  assign cfg_load    = bus.cfg_we && (outst_q == '0);

  always_comb begin
    cfg_ok_d  = cfg_ok_q | cfg_load;
    cfg_err_d = bus.cfg_we && (outst_q != '0);
    ptr_d     = issue ? win_id : ptr_q;

    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = issue;
    tag_id_d[0] = win_id;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end

    outst_d = outst_q;
    if (issue && !pop) begin
      outst_d = outst_q + CW'(1);
    end else if (pop && !issue) begin
      outst_d = outst_q - CW'(1);
    end

    dp_a_d = dp_a_q;
    dp_b_d = dp_b_q;
    if (issue) begin
      dp_a_d = win_id ? bus.req1_a : bus.req0_a;
      dp_b_d = win_id ? bus.req1_b : bus.req0_b;
    end

    dp_q_d  = cfg_load ? bus.cfg_q  : dp_q_q;
    dp_mu_d = cfg_load ? bus.cfg_mu : dp_mu_q;
    dp_k_d  = cfg_load ? bus.cfg_k  : dp_k_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ok_q  <= 1'b0;
      ptr_q     <= 1'b1;
      cfg_err_q <= 1'b0;
      tag_v_q   <= '0;
      tag_id_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      outst_q   <= '0;
      dp_a_q    <= '0;
      dp_b_q    <= '0;
      dp_q_q    <= '0;
      dp_mu_q   <= '0;
      dp_k_q    <= '0;
    end else begin
      cfg_ok_q  <= cfg_ok_d;
      ptr_q     <= ptr_d;
      cfg_err_q <= cfg_err_d;
      tag_v_q   <= tag_v_d;
      tag_id_q  <= tag_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      outst_q   <= outst_d;
      dp_a_q    <= dp_a_d;
      dp_b_q    <= dp_b_d;
      dp_q_q    <= dp_q_d;
      dp_mu_q   <= dp_mu_d;
      dp_k_q    <= dp_k_d;
    end
  end

  // Storage is not reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_t_q[wr_ptr_q]  <= bus.dp_t;
      mem_id_q[wr_ptr_q] <= tag_id_q[LAT-1];
    end
  end

  assign bus.req0_ready = issue && !win_id;
  assign bus.req1_ready = issue && win_id;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.dp_q       = dp_q_q;
  assign bus.dp_mu      = dp_mu_q;
  assign bus.dp_k       = dp_k_q;
  assign bus.rsp_valid  = fifo_nempty;
  assign bus.rsp_id     = fifo_nempty && mem_id_q[rd_ptr_q];
  assign bus.rsp_t      = fifo_nempty ? mem_t_q[rd_ptr_q] : 64'd0;
endmodule
